// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter sharing the single SoC memory path (bram0, bram1 ROM,
//   spram) between the monitor (port M) and the cpu (port C). Bounded bursts,
//   a per-access combinational ack, and tagged read-data return.
//
// Ports
//   CLK, reset            clock; synchronous active-low reset
//   m_req/m_we/m_addr/m_wdata   monitor request, held stable until m_ack
//   m_ack                 monitor access issued this cycle (write commits at edge)
//   m_rvalid/m_rdata      monitor read return (one-cycle pulse / held data)
//   c_*                   same set for the cpu
//   ram_raddr/ram_waddr   winner address (both identical)
//   ram_data_in           winner write data
//   ram_write             winner is a write
//   ram_data_out          read data from the decoded memory mux
//   owner                 registered state: 00 idle, 01 M, 10 C
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | no access granted last cycle; ties go to != last
// ST_OWN_M | M was granted last cycle; may keep it for a burst
// ST_OWN_C | C was granted last cycle; may keep it for a burst
module mem_arbiter #(
  parameter int AW         = 18,
  parameter int RD_LATENCY = 1,
  parameter int BURST_MAX  = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [7:0]    m_wdata,
  output logic          m_ack,
  output logic          m_rvalid,
  output logic [7:0]    m_rdata,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [7:0]    c_wdata,
  output logic          c_ack,
  output logic          c_rvalid,
  output logic [7:0]    c_rdata,
  output logic [AW-1:0] ram_raddr,
  output logic [AW-1:0] ram_waddr,
  output logic [7:0]    ram_data_in,
  output logic          ram_write,
  input  logic [7:0]    ram_data_out,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_M = 2'b01,
    ST_OWN_C = 2'b10
  } state_t;

  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          last_c_q, last_c_d;   // 1: C was the most recent winner
  logic          win_m, win_c;

  // Winner selection. A lone requester always wins, so a saturated burst
  // counter only forces a switch when the other port is actually waiting.
  always_comb begin
    win_m = 1'b0;
    win_c = 1'b0;
    if (m_req && c_req) begin
      unique case (state_q)
        ST_OWN_M: begin
          if (burst_cnt_q < CNT_MAX) win_m = 1'b1;
          else                       win_c = 1'b1;
        end
        ST_OWN_C: begin
          if (burst_cnt_q < CNT_MAX) win_c = 1'b1;
          else                       win_m = 1'b1;
        end
        default: begin
          if (last_c_q) win_m = 1'b1;
          else          win_c = 1'b1;
        end
      endcase
    end else begin
      win_m = m_req;
      win_c = c_req;
    end
  end

  always_comb begin
    state_d     = ST_IDLE;
    burst_cnt_d = '0;
    last_c_d    = last_c_q;
    if (win_m) begin
      state_d  = ST_OWN_M;
      last_c_d = 1'b0;
      if (state_q == ST_OWN_M)
        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CNT_ONE;
    end else if (win_c) begin
      state_d  = ST_OWN_C;
      last_c_d = 1'b1;
      if (state_q == ST_OWN_C)
        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      last_c_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_c_q    <= last_c_d;
    end
  end

  // Acks and writes are suppressed while reset is held low.
  assign m_ack       = win_m & reset;
  assign c_ack       = win_c & reset;
  assign ram_raddr   = win_c ? c_addr : (win_m ? m_addr : '0);
  assign ram_waddr   = ram_raddr;
  assign ram_data_in = win_c ? c_wdata : (win_m ? m_wdata : 8'h00);
  assign ram_write   = reset & ((win_m & m_we) | (win_c & c_we));
  assign owner       = state_q;

  // Read return pipe: one {valid, tag} stage per cycle of memory latency.
  // tag 1 marks a C read.
  logic [RD_LATENCY-1:0] rd_vld_q, rd_tag_q;
  logic                  rd_out;
  logic [7:0]            m_rdata_q, c_rdata_q;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      rd_vld_q <= '0;
      rd_tag_q <= '0;
    end else begin
      rd_vld_q[0] <= (m_ack & ~m_we) | (c_ack & ~c_we);
      rd_tag_q[0] <= win_c;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_tag_q[i] <= rd_tag_q[i-1];
      end
    end
  end

  // Gating with reset discards a return that lands in a reset cycle.
  assign rd_out   = rd_vld_q[RD_LATENCY-1] & reset;
  assign m_rvalid = rd_out & ~rd_tag_q[RD_LATENCY-1];
  assign c_rvalid = rd_out &  rd_tag_q[RD_LATENCY-1];

  // rdata shows the memory bus during the return pulse and holds afterwards.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      m_rdata_q <= 8'h00;
      c_rdata_q <= 8'h00;
    end else begin
      if (m_rvalid) m_rdata_q <= ram_data_out;
      if (c_rvalid) c_rdata_q <= ram_data_out;
    end
  end

  assign m_rdata = m_rvalid ? ram_data_out : m_rdata_q;
  assign c_rdata = c_rvalid ? ram_data_out : c_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 18;
  localparam int RD_LATENCY = 1;
  localparam int BURST_MAX = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic          m_req, m_we, c_req, c_we;
  logic [AW-1:0] m_addr, c_addr;
  logic [7:0]    m_wdata, c_wdata;
  logic          m_ack, m_rvalid, c_ack, c_rvalid;
  logic [7:0]    m_rdata, c_rdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [7:0]    ram_data_in, ram_data_out;
  logic          ram_write;
  logic [1:0]    owner;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.AW(AW), .RD_LATENCY(RD_LATENCY), .BURST_MAX(BURST_MAX)) dut (
    .CLK(CLK), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_data_in(ram_data_in),
    .ram_write(ram_write), .ram_data_out(ram_data_out), .owner(owner)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Initial memory contents: any address not yet written holds pat(addr).
  function automatic logic [7:0] pat(input int a);
    if (a == 16) return 8'h5A;
    return 8'(a ^ (a >> 7) ^ 13);
  endfunction

  // Memory attached to the DUT's ram bus, one cycle read latency.
  logic [7:0] ram_wr [int];
  always @(posedge CLK) begin
    ram_data_out <= ram_wr.exists(int'(ram_raddr)) ? ram_wr[int'(ram_raddr)] : pat(int'(ram_raddr));
    if (ram_write) ram_wr[int'(ram_waddr)] = ram_data_in;
  end

  // Reference model: grants by run length, expected reads as a due-time queue.
  typedef struct {int port; logic [7:0] data; int due;} rd_t;
  rd_t        rdq[$];
  logic [7:0] ref_wr [int];
  int         mdl_owner = 0;   // 0 none, 1 M, 2 C
  int         mdl_last  = 2;
  int         mdl_run   = 0;   // consecutive grants to mdl_owner
  int         last_win  = 0;
  int         cyc       = 0;
  logic [7:0] exp_m_rdata = 8'h00;
  logic [7:0] exp_c_rdata = 8'h00;

  function automatic int pick_winner();
    if (m_req && c_req) begin
      if (mdl_owner == 0)             return (mdl_last == 1) ? 2 : 1;
      else if (mdl_run < BURST_MAX)   return mdl_owner;
      else                            return 3 - mdl_owner;
    end
    if (m_req) return 1;
    if (c_req) return 2;
    return 0;
  endfunction

  initial begin : cmp
    int win;
    logic ev_m, ev_c, w_we;
    logic [AW-1:0] w_addr;
    logic [7:0] w_data;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      #2;
      chk("owner", owner, mdl_owner);
      ev_m = 1'b0;
      ev_c = 1'b0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        if (reset) begin
          if (rdq[0].port == 1) begin ev_m = 1'b1; exp_m_rdata = rdq[0].data; end
          else                  begin ev_c = 1'b1; exp_c_rdata = rdq[0].data; end
        end
        void'(rdq.pop_front());
      end
      chk("m_rvalid", m_rvalid, ev_m);
      chk("c_rvalid", c_rvalid, ev_c);
      chk("m_rdata", m_rdata, exp_m_rdata);
      chk("c_rdata", c_rdata, exp_c_rdata);

      win    = reset ? pick_winner() : 0;
      w_we   = (win == 1) ? m_we : (win == 2) ? c_we : 1'b0;
      w_addr = (win == 2) ? c_addr : m_addr;
      w_data = (win == 2) ? c_wdata : m_wdata;
      chk("m_ack", m_ack, win == 1);
      chk("c_ack", c_ack, win == 2);
      chk("ram_write", ram_write, w_we);
      if (win != 0) begin
        chk("ram_raddr", ram_raddr, w_addr);
        chk("ram_waddr", ram_waddr, w_addr);
        if (w_we) chk("ram_data_in", ram_data_in, w_data);
      end

      if (!reset) begin
        mdl_owner = 0; mdl_last = 2; mdl_run = 0;
        rdq.delete();
        exp_m_rdata = 8'h00; exp_c_rdata = 8'h00;
      end else if (win == 0) begin
        mdl_owner = 0; mdl_run = 0;
      end else begin
        mdl_run   = (win == mdl_owner) ? mdl_run + 1 : 1;
        mdl_owner = win;
        mdl_last  = win;
        if (w_we) ref_wr[int'(w_addr)] = w_data;
        else rdq.push_back('{win,
             ref_wr.exists(int'(w_addr)) ? ref_wr[int'(w_addr)] : pat(int'(w_addr)),
             cyc + RD_LATENCY});
      end
      last_win = win;
      cyc++;
    end
  end

  // Protocol-respecting random requester: fields stay put while pending.
  task automatic next_req(input logic req, input logic granted, inout logic we,
                          inout logic [AW-1:0] addr, inout logic [7:0] wd, output logic req_n);
    if (req && !granted && $urandom_range(0, 15) != 0) begin
      req_n = 1'b1;
    end else begin
      req_n = ($urandom_range(0, 99) < 65);
      we    = ($urandom_range(0, 2) == 0);
      addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      wd    = 8'($urandom);
    end
  endtask

  initial begin : stim
    reset = 1'b0;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = 0;
    c_req = 1; c_we = 0; c_addr = 18'h3; c_wdata = 0;

    // Post-reset behaviour.
    repeat (2) begin
      @(negedge CLK); #3;
      chk("rst_c_ack", c_ack, 0);
      chk("rst_owner", owner, 0);
    end
    @(negedge CLK); reset = 1'b1; #3;
    chk("first_c_ack", c_ack, 1);
    chk("first_owner", owner, 0);
    @(negedge CLK); #3;
    chk("owner_c", owner, 2'b10);

    // Single M read.
    @(negedge CLK); c_req = 0; m_req = 1; m_we = 0; m_addr = 18'h00010; #3;
    chk("mrd_ack", m_ack, 1);
    @(negedge CLK); m_req = 0; #3;
    chk("mrd_rvalid", m_rvalid, 1);
    chk("mrd_rdata", m_rdata, 8'h5A);
    chk("mrd_c_rvalid", c_rvalid, 0);

    // Contention from a fresh reset: M x4, C x4, M x4.
    @(negedge CLK); reset = 0;
    @(negedge CLK); reset = 1;
    m_req = 1; c_req = 1; m_we = 0; c_we = 0; m_addr = 18'h20; c_addr = 18'h30;
    for (int i = 0; i < 12; i++) begin
      #3;
      chk("burst_m_ack", m_ack, ((i / 4) % 2) == 0);
      chk("burst_c_ack", c_ack, ((i / 4) % 2) == 1);
      @(negedge CLK);
    end

    // Sole requester, no gap.
    m_req = 0; c_req = 1;
    for (int i = 0; i < 10; i++) begin
      #3; chk("sole_c_ack", c_ack, 1);
      @(negedge CLK);
    end
    c_req = 0;
    @(negedge CLK);

    // Mixed traffic.
    m_req = 1; m_we = 0; m_addr = 18'h00100; #3;
    chk("mix_m_ack", m_ack, 1);
    chk("mix_wr0", ram_write, 0);
    @(negedge CLK);
    m_req = 0; c_req = 1; c_we = 1; c_addr = 18'h02000; c_wdata = 8'hA5; #3;
    chk("mix_cw_ack", c_ack, 1);
    chk("mix_wr1", ram_write, 1);
    chk("mix_m_rvalid", m_rvalid, 1);
    @(negedge CLK);
    c_we = 0; #3;
    chk("mix_cr_ack", c_ack, 1);
    chk("mix_wr2", ram_write, 0);
    @(negedge CLK);
    c_req = 0; #3;
    chk("mix_c_rvalid", c_rvalid, 1);
    chk("mix_c_rdata", c_rdata, 8'hA5);
    @(negedge CLK);

    // Reset with a read in flight.
    m_req = 1; m_we = 0; m_addr = 18'h10; #3;
    chk("rmr_ack", m_ack, 1);
    @(negedge CLK);
    m_req = 0; reset = 0; #3;
    chk("rmr_no_rvalid", m_rvalid, 0);
    @(negedge CLK);
    reset = 1; m_req = 1; c_req = 1; c_we = 0; #3;
    chk("rmr_owner_idle", owner, 0);
    chk("rmr_tie_m", m_ack, 1);
    chk("rmr_tie_c", c_ack, 0);
    @(negedge CLK);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      next_req(m_req, last_win == 1, m_we, m_addr, m_wdata, m_req);
      next_req(c_req, last_win == 2, c_we, c_addr, c_wdata, c_req);
      @(negedge CLK);
    end
    m_req = 0; c_req = 0;
    repeat (4) @(negedge CLK);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
